// File: rtl/lfsr6_pkg.sv
// rtl/lfsr6_pkg.sv - shared definitions for the 6-bit LFSR pattern path
//
// Purpose: word width, checker FSM state type and the LFSR next-state
// function. The function is bit-exact to the pattern generator and is also
// used by the generator's testbench, so it must stay identical on both ends.
// Ports: none (package).

package lfsr6_pkg;

  localparam int LFSR6_W = 6;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_SYNC,
    CHK_LOCKED
  } chk_state_t;

  function automatic logic [LFSR6_W-1:0] lfsr6_next(input logic [5:0] s);
    logic [LFSR6_W-1:0] n;
    n[5] = s[0];
    n[4] = s[0] ^ s[5];
    n[3] = s[4];
    n[2] = s[0] ^ s[3];
    n[1] = s[2];
    n[0] = s[1];
    return n;
  endfunction

endpackage

// File: rtl/lfsr6_checker.sv
// rtl/lfsr6_checker.sv - receive-side checker for the 6-bit LFSR pattern
//
// Purpose: locks onto the incoming LFSR word stream, then flywheels a local
// copy of the LFSR and flags every received word that differs from it.
// Optional feature macro: LFSR6_CHK_ERRCNT_EN (when undefined, err_count is
// tied to zero; everything else is unchanged).
//
// Parameters:
//   LOCK_CNT   consecutive matches in SYNC needed to declare lock (>=1)
//   UNLOCK_CNT consecutive mismatches in LOCKED that drop lock (>=1)
//   ERR_W      width of the saturating error counter
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of err_count (FSM unaffected)
//   in_valid   in_data carries a sequence word this cycle
//   in_data    received LFSR word
//   locked     checker is in LOCKED (registered)
//   err_pulse  one-cycle strobe for a mismatch seen while LOCKED (registered)
//   err_count  saturating count of LOCKED mismatches (registered)

module lfsr6_checker
  import lfsr6_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [LFSR6_W-1:0] in_data,
  output logic               locked,
  output logic               err_pulse,
  output logic [ERR_W-1:0]   err_count
);

  localparam int MATCH_W = (LOCK_CNT   < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = (UNLOCK_CNT < 2) ? 1 : $clog2(UNLOCK_CNT + 1);

  chk_state_t           state_q, state_d;
  logic [LFSR6_W-1:0]   exp_q, exp_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                 locked_q;
  logic                 err_pulse_q;
  logic                 err_hit_d;
  logic                 data_zero;

  assign data_zero = (in_data == '0);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_hit_d   = 1'b0;

    if (in_valid) begin
      case (state_q)
        CHK_IDLE: begin
          // All-zero is the LFSR lock-up state and can never seed the sequence.
          if (!data_zero) begin
            exp_d       = lfsr6_next(in_data);
            match_cnt_d = '0;
            state_d     = CHK_SYNC;
          end
        end

        CHK_SYNC: begin
          // Self-synchronising: prediction always reloads from the received word.
          exp_d = lfsr6_next(in_data);
          if (data_zero) begin
            match_cnt_d = '0;
            state_d     = CHK_IDLE;
          end else if (in_data == exp_q) begin
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              match_cnt_d = '0;
              miss_cnt_d  = '0;
              state_d     = CHK_LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end

        CHK_LOCKED: begin
          // Flywheel: prediction advances from itself so a corrupt word does
          // not disturb it. exp is never zero here, so a zero word mismatches.
          exp_d = lfsr6_next(exp_q);
          if (in_data != exp_q) begin
            err_hit_d = 1'b1;
            if (miss_cnt_q == MISS_W'(UNLOCK_CNT - 1)) begin
              miss_cnt_d  = '0;
              match_cnt_d = '0;
              exp_d       = lfsr6_next(in_data);
              state_d     = CHK_SYNC;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end

        default: begin
          state_d     = CHK_IDLE;
          exp_d       = '0;
          match_cnt_d = '0;
          miss_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CHK_IDLE;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= (state_d == CHK_LOCKED);
      err_pulse_q <= err_hit_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

`ifdef LFSR6_CHK_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  // clr takes priority over an error counted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (clr) begin
      err_cnt_q <= '0;
    end else if (err_hit_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_lfsr6_checker.sv
// tb/tb_lfsr6_checker.sv - directed table-driven bench for lfsr6_checker

module tb_lfsr6_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [5:0] in_data;
  logic       locked;
  logic       err_pulse;
  logic [1:0] err_count;

  always #5 clk = ~clk;

`ifdef LFSR6_CHK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  lfsr6_checker #(
    .LOCK_CNT  (4),
    .UNLOCK_CNT(3),
    .ERR_W     (2)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  typedef struct {
    bit         rst;
    bit         valid;
    bit         clr;
    logic [5:0] data;
    bit         e_locked;
    bit         e_pulse;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input bit r, input bit v, input bit c, input logic [5:0] d,
                              input bit l, input bit p, input logic [1:0] n);
    vec_t x;
    x.rst = r; x.valid = v; x.clr = c; x.data = d;
    x.e_locked = l; x.e_pulse = p; x.e_cnt = n;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic check_outs(input string tag, input bit l, input bit p, input logic [1:0] n);
    logic [1:0] want_cnt;
    want_cnt = CNT_EN ? n : 2'd0;
    check({tag, "_locked"}, {31'd0, locked}, {31'd0, l});
    check({tag, "_pulse"}, {31'd0, err_pulse}, {31'd0, p});
    check({tag, "_count"}, {30'd0, err_count}, {30'd0, want_cnt});
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0; in_data = 6'h00;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic beat(input bit v, input bit c, input logic [5:0] d);
    @(negedge clk);
    in_valid = v; clr = c; in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 6'h00;

    // rst, valid, clr, data, locked, pulse, count
    // Lock-in, single corrupt word, loss of lock, relock, clr priority, saturation.
    add(1, 0, 0, 6'h00, 0, 0, 0);
    add(0, 1, 0, 6'h01, 0, 0, 0);
    add(0, 1, 0, 6'h34, 0, 0, 0);
    add(0, 1, 0, 6'h1A, 0, 0, 0);
    add(0, 1, 0, 6'h0D, 0, 0, 0);
    add(0, 1, 0, 6'h32, 1, 0, 0);
    add(0, 1, 0, 6'h19, 1, 0, 0);
    add(0, 1, 0, 6'h3F, 1, 1, 1);  // corrupt in place of 38
    add(0, 1, 0, 6'h1C, 1, 0, 1);
    add(0, 1, 0, 6'h0E, 1, 0, 1);
    add(0, 0, 1, 6'h00, 1, 0, 0);  // clr on an idle beat
    add(0, 1, 0, 6'h3F, 1, 1, 1);  // expected 07
    add(0, 1, 0, 6'h3F, 1, 1, 2);  // expected 37
    add(0, 1, 0, 6'h3F, 0, 1, 3);  // expected 2F, third miss drops lock
    add(0, 1, 0, 6'h23, 0, 0, 3);  // SYNC predicted 2B -> no match
    add(0, 1, 0, 6'h25, 0, 0, 3);
    add(0, 1, 0, 6'h26, 0, 0, 3);
    add(0, 1, 0, 6'h13, 0, 0, 3);
    add(0, 1, 0, 6'h3D, 1, 0, 3);  // fourth match relocks
    add(0, 1, 0, 6'h2A, 1, 0, 3);
    add(0, 1, 1, 6'h3F, 1, 1, 0);  // clr with error: clr wins
    add(0, 1, 0, 6'h3E, 1, 0, 0);
    add(0, 1, 0, 6'h1F, 1, 0, 0);
    add(0, 1, 0, 6'h00, 1, 1, 1);  // zero word while locked (expected 3B)
    add(0, 1, 0, 6'h3F, 1, 1, 2);  // expected 29
    add(0, 1, 0, 6'h20, 1, 0, 2);
    add(0, 1, 0, 6'h3F, 1, 1, 3);  // expected 10
    add(0, 1, 0, 6'h3F, 1, 1, 3);  // expected 08, saturated
    add(0, 1, 0, 6'h04, 1, 0, 3);
    add(0, 1, 0, 6'h3F, 1, 1, 3);  // fifth error, still saturated
    add(0, 1, 0, 6'h01, 1, 0, 3);
    add(0, 1, 0, 6'h34, 1, 0, 3);
    // Gaps between valid beats.
    add(1, 0, 0, 6'h00, 0, 0, 0);
    add(0, 1, 0, 6'h01, 0, 0, 0);
    add(0, 0, 0, 6'h2A, 0, 0, 0);
    add(0, 1, 0, 6'h34, 0, 0, 0);
    add(0, 0, 0, 6'h00, 0, 0, 0);
    add(0, 0, 0, 6'h3F, 0, 0, 0);
    add(0, 1, 0, 6'h1A, 0, 0, 0);
    add(0, 1, 0, 6'h0D, 0, 0, 0);
    add(0, 0, 0, 6'h00, 0, 0, 0);
    add(0, 1, 0, 6'h32, 1, 0, 0);
    add(0, 0, 0, 6'h11, 1, 0, 0);
    add(0, 1, 0, 6'h19, 1, 0, 0);
    add(0, 1, 0, 6'h3F, 1, 1, 1);  // expected 38
    add(0, 0, 0, 6'h00, 1, 0, 1);  // pulse lasts one cycle
    add(0, 1, 0, 6'h1C, 1, 0, 1);
    // Zero words in IDLE and SYNC.
    add(1, 0, 0, 6'h00, 0, 0, 0);
    add(0, 1, 0, 6'h00, 0, 0, 0);
    add(0, 1, 0, 6'h01, 0, 0, 0);
    add(0, 1, 0, 6'h34, 0, 0, 0);
    add(0, 1, 0, 6'h1A, 0, 0, 0);
    add(0, 1, 0, 6'h00, 0, 0, 0);  // back to IDLE
    add(0, 1, 0, 6'h01, 0, 0, 0);
    add(0, 1, 0, 6'h34, 0, 0, 0);
    add(0, 1, 0, 6'h1A, 0, 0, 0);
    add(0, 1, 0, 6'h0D, 0, 0, 0);
    add(0, 1, 0, 6'h32, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        do_reset();
        #1;
      end else begin
        beat(vecs[i].valid, vecs[i].clr, vecs[i].data);
      end
      check_outs($sformatf("row%0d", i), vecs[i].e_locked, vecs[i].e_pulse, vecs[i].e_cnt);
    end

    // Asynchronous reset mid-operation while locked with two errors counted.
    do_reset();
    beat(1, 0, 6'h01);
    beat(1, 0, 6'h34);
    beat(1, 0, 6'h1A);
    beat(1, 0, 6'h0D);
    beat(1, 0, 6'h32);
    check_outs("pre_lock", 1, 0, 0);
    beat(1, 0, 6'h3F);
    beat(1, 0, 6'h3F);
    check_outs("pre_rst", 1, 1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1, 0, 6'h01);
    beat(1, 0, 6'h34);
    beat(1, 0, 6'h1A);
    beat(1, 0, 6'h0D);
    check_outs("relock_partial", 0, 0, 0);
    beat(1, 0, 6'h32);
    check_outs("relock_full", 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
